// File: rtl/store_buffer_pkg.sv
// Shared constants and types for the CPU store buffer.
package store_buffer_pkg;

  // Default geometry: four pending stores of 16-bit words, 10-bit word addresses.
  localparam int SB_DEPTH  = 4;
  localparam int SB_ADDR_W = 10;
  localparam int SB_DATA_W = 16;

  // One pending store at the default widths: target word address and its data.
  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sbEntry_t;

endpackage

// File: rtl/sb_forward_sel.sv
// Youngest-match selector: walks the pending stores from oldest to youngest
// so that the last matching valid entry (the youngest) supplies the data.
module sb_forward_sel
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic [DEPTH-1:0][ADDR_W-1:0] entryAddr,
  input  logic [DEPTH-1:0][DATA_W-1:0] entryData,
  input  logic [DEPTH-1:0]             entryValid,
  input  logic [$clog2(DEPTH)-1:0]     headPtr,
  input  logic [ADDR_W-1:0]            lookupAddr,
  output logic                         hit,
  output logic [DATA_W-1:0]            hitData
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] slot_s;

  // Scan in age order starting at the head; later (younger) matches override.
  always_comb begin
    hit     = 1'b0;
    hitData = '0;
    slot_s  = headPtr;
    for (int k = 0; k < DEPTH; k++) begin
      slot_s = headPtr + PTR_W'(k);
      if (entryValid[slot_s] && (entryAddr[slot_s] == lookupAddr)) begin
        hit     = 1'b1;
        hitData = entryData[slot_s];
      end else begin
        hit     = hit;
        hitData = hitData;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between a CPU and a single-ported data memory. Stores are queued
// and written back when the memory port is free (idle cycles) or when the queue
// is full and the CPU is stalled; loads see pending stores through forwarding.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic [ADDR_W-1:0] cpuAddress,
  input  logic [DATA_W-1:0] cpuWriteData,
  input  logic              cpuMemWrite,
  input  logic              cpuMemRead,
  output logic [DATA_W-1:0] cpuReadData,
  output logic              stall,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0] memWriteData,
  output logic              memWriteEn,
  input  logic [DATA_W-1:0] memReadData,
  output logic              bufferEmpty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t [DEPTH-1:0]  entries_r;
  logic [DEPTH-1:0]    valid_r;
  logic [PTR_W-1:0]    headPtr_r;
  logic [PTR_W-1:0]    tailPtr_r;
  logic [CNT_W-1:0]    count_r;

  logic                full_s;
  logic                empty_s;
  logic                push_s;
  logic                drain_s;
  logic                fwdHit_s;
  logic [DATA_W-1:0]   fwdData_s;
  logic [DEPTH-1:0][ADDR_W-1:0] entryAddr_s;
  logic [DEPTH-1:0][DATA_W-1:0] entryData_s;

  assign full_s  = (count_r == FULL_CNT);
  assign empty_s = (count_r == '0);
  // A store while full is refused; the stalled cycle is used to drain the head.
  assign stall   = full_s & cpuMemWrite;
  assign push_s  = cpuMemWrite & ~stall;
  // The memory port is ours whenever the CPU does not need it, or while stalled.
  assign drain_s = ~empty_s & ((~cpuMemRead & ~cpuMemWrite) | stall);
  assign bufferEmpty = empty_s;

  // Split the entry array into address and data planes for the selector.
  always_comb begin
    entryAddr_s = '0;
    entryData_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entryAddr_s[i] = entries_r[i].addr;
      entryData_s[i] = entries_r[i].data;
    end
  end

  sb_forward_sel #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_forward (
    .entryAddr  (entryAddr_s),
    .entryData  (entryData_s),
    .entryValid (valid_r),
    .headPtr    (headPtr_r),
    .lookupAddr (cpuAddress),
    .hit        (fwdHit_s),
    .hitData    (fwdData_s)
  );

  // Memory port: head entry while draining, otherwise the CPU request passes through.
  always_comb begin
    memAddress   = cpuAddress;
    memWriteData = cpuWriteData;
    memWriteEn   = 1'b0;
    if (drain_s) begin
      memAddress   = entries_r[headPtr_r].addr;
      memWriteData = entries_r[headPtr_r].data;
      memWriteEn   = 1'b1;
    end else begin
      memAddress   = cpuAddress;
      memWriteData = cpuWriteData;
      memWriteEn   = 1'b0;
    end
  end

  // Load result: youngest pending store to this address wins over memory.
  always_comb begin
    cpuReadData = memReadData;
    if (fwdHit_s) begin
      cpuReadData = fwdData_s;
    end else begin
      cpuReadData = memReadData;
    end
  end

  // Queue bookkeeping: pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      headPtr_r <= '0;
      tailPtr_r <= '0;
      count_r   <= '0;
    end else begin
      if (push_s) begin
        tailPtr_r <= tailPtr_r + PTR_ONE;
      end
      if (drain_s) begin
        headPtr_r <= headPtr_r + PTR_ONE;
      end
      case ({push_s, drain_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage: write at the tail on accept, invalidate the head on drain.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      entries_r <= '0;
      valid_r   <= '0;
    end else begin
      if (push_s) begin
        entries_r[tailPtr_r] <= '{addr: cpuAddress, data: cpuWriteData};
        valid_r[tailPtr_r]   <= 1'b1;
      end
      if (drain_s) begin
        valid_r[headPtr_r] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a behavioural data memory and a
// scoreboard of expected memory writes and load results.
`timescale 1ns/1ps
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rstN;
  logic [9:0]  cpuAddress;
  logic [15:0] cpuWriteData;
  logic        cpuMemWrite;
  logic        cpuMemRead;
  logic [15:0] cpuReadData;
  logic        stall;
  logic [9:0]  memAddress;
  logic [15:0] memWriteData;
  logic        memWriteEn;
  logic [15:0] memReadData;
  logic        bufferEmpty;

  logic [15:0] mem [0:1023];
  logic [25:0] writeQ [$];
  logic [15:0] loadQ [$];
  int tests = 0;
  int fails = 0;

  store_buffer dut (
    .clk          (clk),
    .rstN         (rstN),
    .cpuAddress   (cpuAddress),
    .cpuWriteData (cpuWriteData),
    .cpuMemWrite  (cpuMemWrite),
    .cpuMemRead   (cpuMemRead),
    .cpuReadData  (cpuReadData),
    .stall        (stall),
    .memAddress   (memAddress),
    .memWriteData (memWriteData),
    .memWriteEn   (memWriteEn),
    .memReadData  (memReadData),
    .bufferEmpty  (bufferEmpty)
  );

  always #5 clk = ~clk;

  // Behavioural data memory: combinational read, clocked write.
  assign memReadData = mem[memAddress];
  always @(posedge clk) begin
    if (memWriteEn) mem[memAddress] <= memWriteData;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every memory write and every load against the queues.
  always @(negedge clk) begin
    if (rstN && memWriteEn) begin
      if (writeQ.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected write: addr 0x%0h data 0x%0h, none expected", memAddress, memWriteData);
      end else begin
        logic [25:0] e;
        e = writeQ.pop_front();
        check("memWrite addr", {22'd0, memAddress}, {22'd0, e[25:16]});
        check("memWrite data", {16'd0, memWriteData}, {16'd0, e[15:0]});
      end
    end
    if (rstN && cpuMemRead && !cpuMemWrite && loadQ.size() > 0) begin
      logic [15:0] l;
      l = loadQ.pop_front();
      check("load data", {16'd0, cpuReadData}, {16'd0, l});
    end
  end

  task automatic store(input logic [9:0] a, input logic [15:0] d, input logic rd);
    cpuAddress   = a;
    cpuWriteData = d;
    cpuMemWrite  = 1'b1;
    cpuMemRead   = rd;
    writeQ.push_back({a, d});
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!stall) break;
      @(posedge clk); #1;
    end
    check("store accepted", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    cpuMemWrite = 1'b0;
    cpuMemRead  = 1'b0;
  endtask

  task automatic load(input logic [9:0] a, input logic [15:0] exp);
    cpuAddress  = a;
    cpuMemWrite = 1'b0;
    cpuMemRead  = 1'b1;
    loadQ.push_back(exp);
    @(negedge clk);
    check("no write during load", {31'd0, memWriteEn}, 32'd0);
    @(posedge clk); #1;
    cpuMemRead = 1'b0;
  endtask

  task automatic waitEmpty();
    cpuMemWrite = 1'b0;
    cpuMemRead  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bufferEmpty) break;
    end
    check("drain done", {31'd0, bufferEmpty}, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[505] = 16'h0006;
    rstN = 1'b0;
    cpuAddress = 10'd0; cpuWriteData = 16'h0000;
    cpuMemWrite = 1'b0; cpuMemRead = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset stall", {31'd0, stall}, 32'd0);
    check("reset memWriteEn", {31'd0, memWriteEn}, 32'd0);
    check("reset bufferEmpty", {31'd0, bufferEmpty}, 32'd1);
    check("reset readData", {16'd0, cpuReadData}, {16'd0, mem[10'd0]});
    rstN = 1'b1;
    @(posedge clk); #1;

    // Single store drains on the next idle cycle
    store(10'd10, 16'h1234, 1'b0);
    @(negedge clk);
    check("drain en", {31'd0, memWriteEn}, 32'd1);
    check("drain addr", {22'd0, memAddress}, 32'd10);
    check("drain data", {16'd0, memWriteData}, 32'h1234);
    check("not empty", {31'd0, bufferEmpty}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("empty after drain", {31'd0, bufferEmpty}, 32'd1);
    check("idle no write", {31'd0, memWriteEn}, 32'd0);
    @(posedge clk); #1;

    // Forwarding of a pending store
    store(10'd500, 16'hAAAA, 1'b0);
    load(10'd500, 16'hAAAA);
    waitEmpty();
    check("mem[500]", {16'd0, mem[500]}, 32'hAAAA);

    // Youngest of two stores to one address wins, in load and in memory
    store(10'd600, 16'h0001, 1'b0);
    store(10'd600, 16'h0002, 1'b0);
    load(10'd600, 16'h0002);
    waitEmpty();
    check("mem[600]", {16'd0, mem[600]}, 32'h0002);

    // Read and write together are a store only
    store(10'd900, 16'h0909, 1'b1);
    waitEmpty();
    check("mem[900]", {16'd0, mem[900]}, 32'h0909);

    // Fill the queue; the fifth store stalls while the head drains
    for (int i = 0; i < 4; i++) store(10'd700 + 10'(i), 16'h0700 + 16'(i), 1'b0);
    cpuAddress = 10'd704; cpuWriteData = 16'h0704; cpuMemWrite = 1'b1; cpuMemRead = 1'b0;
    writeQ.push_back({10'd704, 16'h0704});
    @(negedge clk);
    check("full stall", {31'd0, stall}, 32'd1);
    check("stall drain en", {31'd0, memWriteEn}, 32'd1);
    check("stall drain addr", {22'd0, memAddress}, 32'd700);
    @(posedge clk); #1;
    @(negedge clk);
    check("stall released", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    waitEmpty();
    for (int i = 0; i < 5; i++)
      check("mem[700+i]", {16'd0, mem[700 + i]}, {16'd0, 16'h0700 + 16'(i)});

    // Load from memory with nothing pending
    load(10'd505, 16'h0006);

    // Reset mid-cycle discards three pending stores
    store(10'd800, 16'h0800, 1'b0);
    store(10'd801, 16'h0801, 1'b0);
    store(10'd802, 16'h0802, 1'b0);
    #2 rstN = 1'b0;
    #1;
    writeQ.delete();
    check("rst bufferEmpty", {31'd0, bufferEmpty}, 32'd1);
    check("rst memWriteEn", {31'd0, memWriteEn}, 32'd0);
    check("rst stall", {31'd0, stall}, 32'd0);
    check("rst readData", {16'd0, cpuReadData}, {16'd0, mem[10'd802]});
    #3 rstN = 1'b1;
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1;
    check("mem[800] untouched", {16'd0, mem[800]}, 32'd0);
    check("mem[802] untouched", {16'd0, mem[802]}, 32'd0);
    check("write queue empty", writeQ.size(), 32'd0);
    check("load queue empty", loadQ.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
